m_wbgpio: RTL and testbench
===========================

M_WBGPIO -- requirements
Module: m_wbgpio

Interface
REQ-001 SHALL have parameter NOUT, default 4: number of output pins, legal range 1..32.
REQ-002 SHALL have parameter NIN, default 1: number of input pins, legal range 1..32.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal values 2..3.
REQ-004 SHALL have parameter OUT_INIT, default 0: reset value of the output register, NOUT bits.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port CLK_I, input, 1 bit: sole clock, all state on its rising edge.
REQ-007 SHALL have port RST_I, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have Wishbone slave ports: CYC_I, STB_I, WE_I (each input, 1 bit); ADR_I (input, 3 bits, word offset); SEL_I (input, 4 bits); DAT_I (input, 32 bits); DAT_O (output, 32 bits); ACK_O (output, 1 bit).
REQ-009 SHALL have port gpio_in, input, NIN bits: asynchronous pins.
REQ-010 SHALL have port gpio_out, output, NOUT bits: registered pins.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-012 SHALL decode this register map by ADR_I: 0 OUT (R/W); 1 SET (W: OUT|=D); 2 CLR (W: OUT&=~D); 3 TGL (W: OUT^=D); 4 IN (R: synced inputs, writes ignored); 5 RISEEN (R/W); 6 FALLEN (R/W); 7 FLAGS (R, write-1-to-clear).
REQ-013 SHALL apply a write only to the bytes whose SEL_I bit is set, and only on the cycle an access is accepted.
REQ-014 SHALL accept an access when CYC_I&STB_I&~ACK_O; ACK_O is asserted exactly one cycle after acceptance, for one cycle.
REQ-015 SHALL deassert ACK_O for at least one cycle between accesses, so a held STB_I yields alternating ACK_O.
REQ-016 SHALL register DAT_O in the acceptance cycle, drive it valid while ACK_O is high, and drive zero otherwise; SET/CLR/TGL reads return OUT.
REQ-017 SHALL zero-extend unused upper bits on reads and ignore them on writes.
REQ-018 SHALL pass each gpio_in bit through SYNC_STAGES flip-flops; IN returns the last stage.
REQ-019 SHALL hold one further registered copy of the synced input, setting FLAGS[i] on 0->1 when RISEEN[i] and on 1->0 when FALLEN[i].
REQ-020 SHALL let an edge event win over a same-cycle write-1-to-clear on the same bit, leaving the flag set.
REQ-021 SHALL drive irq = |FLAGS, registered, one cycle after the flag sets.
REQ-022 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset release, using an arm counter, so pins already high never raise a false flag.
REQ-023 SHALL drive gpio_out directly from the OUT register, with no combinational path from the bus.

Reset
REQ-024 SHALL, on RST_I, set OUT=OUT_INIT; RISEEN, FALLEN, FLAGS, irq, ACK_O, DAT_O and the sync chain to 0; and the arm counter to disarmed.
REQ-025 SHALL abort any access during which RST_I is high: no write takes effect and no ACK_O is issued.

Structure
REQ-026 SHALL place the register offsets (0..7) as named constants in the shared midgetv peripheral package.
REQ-027 SHALL use one sub-module, m_wbgpio_sync, holding the per-bit synchroniser and edge detector, instantiated NIN times.

Verification (NOUT=4, NIN=4, OUT_INIT=4'h5)
REQ-028 SHALL cover: reset release -> gpio_out=4'h5, irq=0; read OUT -> 32'h5, with ACK_O exactly 1 cycle after STB_I.
REQ-029 SHALL cover: write OUT=32'hA, then SET 32'h1, CLR 32'h8, TGL 32'h6 -> gpio_out 4'hA, 4'hB, 4'h3, 4'h5.
REQ-030 SHALL cover: write OUT with SEL_I=4'b0000 -> gpio_out unchanged, ACK_O still issued.
REQ-031 SHALL cover: RISEEN=4'h2, gpio_in[1] 0->1 -> FLAGS=32'h2 and irq=1 within SYNC_STAGES+2 cycles; write FLAGS=32'h2 -> irq=0 next cycle.
REQ-032 SHALL cover: gpio_in=4'hF held through reset, RISEEN=4'hF -> FLAGS remains 0.
REQ-033 SHALL cover: a falling edge on bit 0 with FALLEN[0]=1 coinciding with a FLAGS write of 32'h1 -> FLAGS[0] remains 1.

Source files
------------

// File: rtl/m_wbgpio_pkg.sv
// Shared definitions for the m_wbgpio Wishbone GPIO peripheral.
// Contains the register offsets and the byte-lane mask helper.
package m_wbgpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT    = 3'd0,
    REG_SET    = 3'd1,
    REG_CLR    = 3'd2,
    REG_TGL    = 3'd3,
    REG_IN     = 3'd4,
    REG_RISEEN = 3'd5,
    REG_FALLEN = 3'd6,
    REG_FLAGS  = 3'd7
  } gpio_reg_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/m_wbgpio_sync.sv
// One input pin: SYNC_STAGES-deep synchroniser plus a delayed copy of the
// synchronised value, used to detect rising and falling edges.
module m_wbgpio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sync_out = chain[SYNC_STAGES-1];
    rise     = chain[SYNC_STAGES-1] & ~prev;
    fall     = ~chain[SYNC_STAGES-1] & prev;
  end

endmodule

// File: rtl/m_wbgpio.sv
// Wishbone GPIO: output register with set/clear/toggle aliases, synchronised
// inputs, per-bit edge flags with write-1-to-clear and a level interrupt.
module m_wbgpio
  import m_wbgpio_pkg::*;
#(
  parameter int unsigned     NOUT        = 4,
  parameter int unsigned     NIN         = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [NOUT-1:0] OUT_INIT    = '0
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [2:0]      ADR_I,
  input  logic [3:0]      SEL_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  gpio_in,
  output logic [NOUT-1:0] gpio_out,
  output logic            irq
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [NOUT-1:0] out_q;
  logic [NIN-1:0]  riseen_q, fallen_q, flags_q, flags_next;
  logic [NIN-1:0]  synced, rise, fall;
  logic            ack_q, irq_q;
  logic [31:0]     dat_q;
  logic [2:0]      arm_cnt;
  logic            armed;

  logic            accept;
  gpio_reg_e       reg_sel;
  logic [31:0]     wmask, wdata, rdata, out_ext;
  logic [31:0]     out_next, riseen_next, fallen_next, flags_clr;
  logic            unused_bits;

  for (genvar g = 0; g < NIN; g++) begin : g_sync
    m_wbgpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (CLK_I),
      .rst      (RST_I),
      .din      (gpio_in[g]),
      .sync_out (synced[g]),
      .rise     (rise[g]),
      .fall     (fall[g])
    );
  end

  always_comb begin
    accept      = CYC_I & STB_I & ~ack_q & ~RST_I;
    reg_sel     = gpio_reg_e'(ADR_I);
    wmask       = byte_mask(SEL_I);
    wdata       = DAT_I & wmask;
    out_ext     = 32'(out_q);
    armed       = (arm_cnt == ARM_CYCLES);
    out_next    = out_ext;
    riseen_next = 32'(riseen_q);
    fallen_next = 32'(fallen_q);
    flags_clr   = '0;
    if (accept && WE_I) begin
      case (reg_sel)
        REG_OUT:    out_next    = (out_ext & ~wmask) | wdata;
        REG_SET:    out_next    = out_ext | wdata;
        REG_CLR:    out_next    = out_ext & ~wdata;
        REG_TGL:    out_next    = out_ext ^ wdata;
        REG_RISEEN: riseen_next = (32'(riseen_q) & ~wmask) | wdata;
        REG_FALLEN: fallen_next = (32'(fallen_q) & ~wmask) | wdata;
        REG_FLAGS:  flags_clr   = wdata;
        default:    ;
      endcase
    end
    // Edge events are OR-ed after the clear so they win over a same-cycle W1C.
    flags_next = (flags_q & ~NIN'(flags_clr)) |
                 (armed ? ((rise & riseen_q) | (fall & fallen_q)) : '0);
    case (reg_sel)
      REG_IN:     rdata = 32'(synced);
      REG_RISEEN: rdata = 32'(riseen_q);
      REG_FALLEN: rdata = 32'(fallen_q);
      REG_FLAGS:  rdata = 32'(flags_q);
      default:    rdata = out_ext;
    endcase
  end

  assign unused_bits = ^{out_next, riseen_next, fallen_next, flags_clr};

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      out_q    <= OUT_INIT;
      riseen_q <= '0;
      fallen_q <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      arm_cnt  <= '0;
    end else begin
      out_q    <= NOUT'(out_next);
      riseen_q <= NIN'(riseen_next);
      fallen_q <= NIN'(fallen_next);
      flags_q  <= flags_next;
      irq_q    <= |flags_q;
      ack_q    <= accept;
      dat_q    <= accept ? rdata : '0;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign gpio_out = out_q;
  assign ACK_O    = ack_q;
  assign DAT_O    = dat_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_m_wbgpio.sv
// Directed bench for m_wbgpio with NOUT=4, NIN=4, OUT_INIT=4'h5.
module tb_m_wbgpio;
  import m_wbgpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_i, dat_o;
  logic        ack;
  logic [3:0]  gin, gout;
  logic        irq;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  m_wbgpio #(
    .NOUT        (4),
    .NIN         (4),
    .SYNC_STAGES (2),
    .OUT_INIT    (4'h5)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .CYC_I    (cyc),
    .STB_I    (stb),
    .WE_I     (we),
    .ADR_I    (adr),
    .SEL_I    (sel),
    .DAT_I    (dat_i),
    .DAT_O    (dat_o),
    .ACK_O    (ack),
    .gpio_in  (gin),
    .gpio_out (gout),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single access; ACK must appear exactly one cycle after STB and then drop.
  task automatic wb(input logic w, input logic [2:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    #1 chk(32'(ack), 32'h0, "ack_before_edge");
    tick();
    chk(32'(ack), 32'h1, "ack_one_cycle");
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk(32'(ack), 32'h0, "ack_drop");
    chk(dat_o, 32'h0, "dat_o_idle_zero");
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_i = '0; gin = 4'h0;
    tick(); tick();
    // Access while in reset is aborted.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = REG_OUT; sel = 4'hF; dat_i = 32'hF;
    tick();
    chk(32'(ack), 32'h0, "rst_no_ack");
    chk(32'(gout), 32'h5, "rst_gpio_out");
    chk(32'(irq), 32'h0, "rst_irq");
    chk(dat_o, 32'h0, "rst_dat_o");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    tick();
    chk(32'(gout), 32'h5, "post_rst_gpio_out");

    wb(1'b0, REG_OUT, 4'hF, 32'h0, rd);
    chk(rd, 32'h5, "read_out_init");

    wb(1'b1, REG_OUT, 4'hF, 32'hA, rd); chk(32'(gout), 32'hA, "write_out");
    wb(1'b1, REG_SET, 4'hF, 32'h1, rd); chk(32'(gout), 32'hB, "set");
    wb(1'b1, REG_CLR, 4'hF, 32'h8, rd); chk(32'(gout), 32'h3, "clr");
    wb(1'b1, REG_TGL, 4'hF, 32'h6, rd); chk(32'(gout), 32'h5, "tgl");

    wb(1'b1, REG_OUT, 4'b0000, 32'hF, rd); chk(32'(gout), 32'h5, "sel_none");
    wb(1'b1, REG_OUT, 4'b0010, 32'hFFFF_FFFF, rd); chk(32'(gout), 32'h5, "sel_byte1_only");
    wb(1'b1, REG_OUT, 4'b0001, 32'hFFFF_FF0C, rd); chk(32'(gout), 32'hC, "sel_byte0");
    wb(1'b0, REG_SET, 4'hF, 32'h0, rd); chk(rd, 32'hC, "read_set_alias");

    // Held STB produces alternating ACK.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = REG_OUT; sel = 4'hF;
    tick(); chk(32'(ack), 32'h1, "held_ack1"); chk(dat_o, 32'hC, "held_dat1");
    tick(); chk(32'(ack), 32'h0, "held_ack2"); chk(dat_o, 32'h0, "held_dat2");
    tick(); chk(32'(ack), 32'h1, "held_ack3");
    tick(); chk(32'(ack), 32'h0, "held_ack4");
    cyc = 1'b0; stb = 1'b0;
    tick();

    wb(1'b0, REG_IN, 4'hF, 32'h0, rd); chk(rd, 32'h0, "read_in_zero");

    // Rising edge on bit 1.
    wb(1'b1, REG_RISEEN, 4'hF, 32'h2, rd);
    wb(1'b0, REG_RISEEN, 4'hF, 32'h0, rd); chk(rd, 32'h2, "riseen_readback");
    gin = 4'h2;
    for (int i = 0; i < 4 && irq !== 1'b1; i++) tick();
    chk(32'(irq), 32'h1, "irq_on_rise");
    wb(1'b0, REG_FLAGS, 4'hF, 32'h0, rd); chk(rd, 32'h2, "flags_rise");
    wb(1'b0, REG_IN, 4'hF, 32'h0, rd); chk(rd, 32'h2, "read_in_synced");
    wb(1'b1, REG_FLAGS, 4'hF, 32'h2, rd);
    chk(32'(irq), 32'h0, "irq_cleared");
    wb(1'b0, REG_FLAGS, 4'hF, 32'h0, rd); chk(rd, 32'h0, "flags_cleared");

    // Pins high through reset must not raise a flag.
    rst = 1'b1; gin = 4'hF;
    tick(); tick(); tick();
    rst = 1'b0;
    wb(1'b1, REG_RISEEN, 4'hF, 32'hF, rd);
    tick(); tick(); tick();
    chk(32'(gout), 32'h5, "second_rst_gpio_out");
    wb(1'b0, REG_FLAGS, 4'hF, 32'h0, rd); chk(rd, 32'h0, "no_false_flag");
    chk(32'(irq), 32'h0, "no_false_irq");

    // Falling edge on bit 0 coinciding with W1C of bit 0.
    wb(1'b1, REG_FALLEN, 4'hF, 32'h1, rd);
    wb(1'b0, REG_FALLEN, 4'hF, 32'h0, rd); chk(rd, 32'h1, "fallen_readback");
    gin = 4'hE;
    tick(); tick();
    wb(1'b1, REG_FLAGS, 4'hF, 32'h1, rd);
    wb(1'b0, REG_FLAGS, 4'hF, 32'h0, rd); chk(rd, 32'h1, "edge_wins_w1c");
    chk(32'(irq), 32'h1, "irq_after_collision");
    wb(1'b1, REG_FLAGS, 4'hF, 32'h1, rd);
    wb(1'b0, REG_FLAGS, 4'hF, 32'h0, rd); chk(rd, 32'h0, "w1c_after_collision");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
